// File: rtl/mfp_ahb_botio.sv
// AHB-Lite slave bridging the MIPS core bus to the RojoBot world-map logic:
// BotInfo snapshot on update, sticky update interrupt, BotCtrl register, ACK pulse.
module mfp_ahb_botio #(
  parameter int unsigned BOTINFO_W = 32,
  parameter int unsigned BOTCTRL_W = 8,
  parameter int unsigned MISS_W    = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [31:0]          HWDATA,
  output logic [31:0]          HRDATA,
  output logic                 HREADY,
  output logic                 HRESP,
  input  logic [BOTINFO_W-1:0] IO_BotInfo,
  input  logic                 IO_BotUpdt_Sync,
  output logic [BOTCTRL_W-1:0] IO_BotCtrl,
  output logic                 IO_INT_ACK,
  output logic                 IRQ
);

  typedef enum logic [1:0] {
    REG_BOTINFO = 2'd0,
    REG_BOTCTRL = 2'd1,
    REG_STATUS  = 2'd2,
    REG_ACK     = 2'd3
  } reg_sel_e;

  reg_sel_e             addr_q;
  logic                 write_q;
  logic                 valid_q;
  logic                 updt_q;
  logic [BOTINFO_W-1:0] snapshot;
  logic [BOTCTRL_W-1:0] botctrl;
  logic                 pending;
  logic [MISS_W-1:0]    missed;
  logic [15:0]          upd_cnt;
  logic                 int_ack_q;

  logic updt_edge;
  logic wr_en;
  logic ack_wr;
  logic unused_bits;

  assign HREADY = 1'b1;
  assign HRESP  = 1'b0;

  assign updt_edge = IO_BotUpdt_Sync & ~updt_q;
  assign wr_en     = valid_q & write_q;
  assign ack_wr    = wr_en & (addr_q == REG_ACK) & HWDATA[0];

  // Only HADDR[3:2], HTRANS[1] and the low data bits carry meaning here.
  assign unused_bits = ^{HADDR, HSIZE, HTRANS, HWDATA};

  // Address phase capture for the following data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= REG_BOTINFO;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= HSEL & HTRANS[1] & HREADY;
      if (HSEL & HTRANS[1] & HREADY) begin
        addr_q  <= reg_sel_e'(HADDR[3:2]);
        write_q <= HWRITE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      botctrl   <= '0;
      int_ack_q <= 1'b0;
    end else begin
      int_ack_q <= ack_wr;
      if (wr_en && addr_q == REG_BOTCTRL)
        botctrl <= HWDATA[BOTCTRL_W-1:0];
    end
  end

  // An update edge coinciding with an ACK keeps pending set and is not a miss.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      updt_q   <= 1'b0;
      snapshot <= '0;
      pending  <= 1'b0;
      missed   <= '0;
      upd_cnt  <= '0;
    end else begin
      updt_q <= IO_BotUpdt_Sync;
      if (updt_edge) begin
        snapshot <= IO_BotInfo;
        pending  <= 1'b1;
        upd_cnt  <= upd_cnt + 16'd1;
        if (pending && !ack_wr && missed != '1)
          missed <= missed + MISS_W'(1);
      end else if (ack_wr) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (valid_q && !write_q) begin
      case (addr_q)
        REG_BOTINFO: HRDATA[BOTINFO_W-1:0] = snapshot;
        REG_BOTCTRL: HRDATA[BOTCTRL_W-1:0] = botctrl;
        REG_STATUS: begin
          HRDATA[0]          = pending;
          HRDATA[8 +: MISS_W] = missed;
          HRDATA[31:16]      = upd_cnt;
        end
        default: HRDATA = '0;
      endcase
    end
  end

  assign IO_BotCtrl = botctrl;
  assign IO_INT_ACK = int_ack_q;
  assign IRQ        = pending;

endmodule

// File: tb/tb_mfp_ahb_botio.sv
// Directed self-checking bench for mfp_ahb_botio.
module tb_mfp_ahb_botio;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] IO_BotInfo;
  logic        IO_BotUpdt_Sync;
  logic [7:0]  IO_BotCtrl;
  logic        IO_INT_ACK;
  logic        IRQ;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] rd;

  mfp_ahb_botio #(.BOTINFO_W(32), .BOTCTRL_W(8), .MISS_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .IO_BotInfo(IO_BotInfo), .IO_BotUpdt_Sync(IO_BotUpdt_Sync),
    .IO_BotCtrl(IO_BotCtrl), .IO_INT_ACK(IO_INT_ACK), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_addr();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = a;
  endtask

  // Returns one cycle after the commit edge.
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    tick();
    idle_addr();
    HWDATA = d;
    tick();
  endtask

  // Returns during the data phase with the read value.
  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0);
    tick();
    idle_addr();
    d = HRDATA;
    tick();
  endtask

  task automatic updt_pulse(input logic [31:0] info, input int unsigned hi_cycles);
    IO_BotInfo = info;
    IO_BotUpdt_Sync = 1'b1;
    repeat (hi_cycles) tick();
    IO_BotUpdt_Sync = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    repeat (3) tick();
    HRESETn = 1'b1;
    tick();
  endtask

  initial begin
    idle_addr();
    HSIZE = 3'b010; HWDATA = '0; IO_BotInfo = '0; IO_BotUpdt_Sync = 1'b0;
    HRESETn = 1'b0;
    #2;
    check("ctrl_in_reset", {24'd0, IO_BotCtrl}, 32'h0);
    do_reset();

    check("reset_ctrl",   {24'd0, IO_BotCtrl}, 32'h0);
    check("reset_irq",    {31'd0, IRQ}, 32'h0);
    check("reset_intack", {31'd0, IO_INT_ACK}, 32'h0);
    check("reset_hready", {31'd0, HREADY}, 32'h1);
    check("reset_hresp",  {31'd0, HRESP}, 32'h0);
    ahb_read(32'h8, rd);
    check("reset_status", rd, 32'h0000_0000);
    check("idle_hrdata", HRDATA, 32'h0);

    ahb_write(32'h4, 32'hFFFF_FFA5);
    check("botctrl_out", {24'd0, IO_BotCtrl}, 32'hA5);
    ahb_read(32'h4, rd);
    check("botctrl_rd", rd, 32'h0000_00A5);

    // Write data phase overlaps the read address phase.
    addr_phase(32'h4, 1'b1);
    tick();
    HWDATA = 32'h0000_005A;
    addr_phase(32'h4, 1'b0);
    tick();
    idle_addr();
    check("b2b_wr_rd", HRDATA, 32'h0000_005A);
    tick();

    ahb_write(32'h0, 32'hFFFF_FFFF);
    ahb_read(32'h0, rd);
    check("ro_write_ignored", rd, 32'h0);

    updt_pulse(32'h1234_5678, 3);
    tick();
    check("irq_after_updt", {31'd0, IRQ}, 32'h1);
    ahb_read(32'h0, rd);
    check("snap1", rd, 32'h1234_5678);
    ahb_read(32'h8, rd);
    check("status1", rd, 32'h0001_0001);

    updt_pulse(32'hCAFE_F00D, 1);
    ahb_read(32'h0, rd);
    check("snap2", rd, 32'hCAFE_F00D);
    ahb_read(32'h8, rd);
    check("status2", rd, 32'h0002_0101);

    ahb_write(32'hC, 32'h0000_0000);
    check("ack_bit0_clear_nopulse", {31'd0, IO_INT_ACK}, 32'h0);
    check("ack_bit0_clear_irq", {31'd0, IRQ}, 32'h1);

    ahb_write(32'hC, 32'h0000_0001);
    check("intack_pulse", {31'd0, IO_INT_ACK}, 32'h1);
    check("irq_cleared", {31'd0, IRQ}, 32'h0);
    tick();
    check("intack_one_cycle", {31'd0, IO_INT_ACK}, 32'h0);
    ahb_read(32'h8, rd);
    check("status_after_ack", rd, 32'h0002_0100);
    ahb_read(32'hC, rd);
    check("ack_reads_zero", rd, 32'h0);

    // Back-to-back ACKs with nothing pending still pulse each time.
    addr_phase(32'hC, 1'b1);
    tick();
    HWDATA = 32'h1;
    tick();
    idle_addr();
    check("b2b_ack_p1", {31'd0, IO_INT_ACK}, 32'h1);
    tick();
    check("b2b_ack_p2", {31'd0, IO_INT_ACK}, 32'h1);
    tick();
    check("b2b_ack_end", {31'd0, IO_INT_ACK}, 32'h0);

    updt_pulse(32'h1111_2222, 1);
    check("irq_set3", {31'd0, IRQ}, 32'h1);
    // Update edge lands on the ACK commit edge.
    addr_phase(32'hC, 1'b1);
    tick();
    idle_addr();
    HWDATA = 32'h1;
    IO_BotInfo = 32'h0BAD_BEEF;
    IO_BotUpdt_Sync = 1'b1;
    tick();
    IO_BotUpdt_Sync = 1'b0;
    check("coll_irq", {31'd0, IRQ}, 32'h1);
    check("coll_intack", {31'd0, IO_INT_ACK}, 32'h1);
    tick();
    ahb_read(32'h0, rd);
    check("coll_snap", rd, 32'h0BAD_BEEF);
    ahb_read(32'h8, rd);
    check("coll_status", rd, 32'h0004_0101);

    do_reset();
    check("reset2_irq", {31'd0, IRQ}, 32'h0);
    for (int i = 0; i < 300; i++) updt_pulse(32'(i), 1);
    ahb_read(32'h8, rd);
    check("sat_status", rd, 32'h012C_FF01);
    ahb_read(32'h0, rd);
    check("sat_snap", rd, 32'd299);

    ahb_write(32'h4, 32'h0000_0033);
    check("pre_rst_ctrl", {24'd0, IO_BotCtrl}, 32'h33);
    addr_phase(32'h4, 1'b1);
    tick();
    idle_addr();
    HWDATA = 32'h0000_0077;
    #2;
    HRESETn = 1'b0;
    #1;
    check("midrst_ctrl_now", {24'd0, IO_BotCtrl}, 32'h0);
    tick();
    tick();
    HRESETn = 1'b1;
    tick();
    check("midrst_ctrl_after", {24'd0, IO_BotCtrl}, 32'h0);
    ahb_read(32'h4, rd);
    check("midrst_ctrl_rd", rd, 32'h0);
    ahb_read(32'h8, rd);
    check("midrst_status", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_botio.md
Name: mfp_ahb_botio

Overview:
- AHB-Lite slave bridging the MIPS core bus to the RojoBot world-map logic.
- Captures a coherent BotInfo snapshot on each bot update event and raises a sticky update-pending interrupt.
- Drives the BotCtrl register from software writes and returns a one-cycle INT_ACK pulse to the bot when software acknowledges an update.
- Sits on the AHB-Lite bus beside the GPIO/memory slaves; its IRQ output feeds an SI_Int bit.

Parameters:
- BOTINFO_W, 32, width of IO_BotInfo and of the snapshot register (max 32).
- BOTCTRL_W, 8, width of the BotCtrl register (max 32).
- MISS_W, 8, width of the saturating missed-update counter (max 8).

Ports:
- HCLK  in  1  bus clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from AHB decoder.
- HADDR  in  32  address; only [3:2] decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means valid (NONSEQ/SEQ).
- HWRITE  in  1  1=write.
- HSIZE  in  3  ignored; every access treated as a word.
- HWDATA  in  32  write data, valid in data phase.
- HRDATA  out  32  read data, valid in data phase.
- HREADY  out  1  constant 1; zero wait states.
- HRESP  out  1  constant 0; OKAY.
- IO_BotInfo  in  BOTINFO_W  live bot status word.
- IO_BotUpdt_Sync  in  1  bot update strobe, already synchronised to HCLK.
- IO_BotCtrl  out  BOTCTRL_W  bot motor/control word.
- IO_INT_ACK  out  1  acknowledge pulse to bot.
- IRQ  out  1  level interrupt = pending flag.

Behaviour:
- Reset (async assert, sync deassert by HCLK domain): all outputs 0 except HREADY=1. Internal state cleared: snapshot, pending, missed, update count, address-phase regs, update-edge reg.
- Address phase: when HSEL & HTRANS[1] & HREADY, register HADDR[3:2] and HWRITE and set a valid flag for the following data phase. Otherwise the valid flag is 0 next cycle.
- Data phase read: HRDATA is driven combinationally from the registered address. Reads in a cycle with no valid data phase return 0.
- Data phase write: HWDATA is committed at the end of the data phase. A read whose data phase follows a write's data phase sees the new value.
- Register map (word offsets):
  - 0x0 BOTINFO RO: snapshot, zero-extended.
  - 0x4 BOTCTRL RW: [BOTCTRL_W-1:0]; upper bits read 0.
  - 0x8 STATUS RO: bit0 pending; [15:8] missed count; [31:16] update count (wraps 0xFFFF->0).
  - 0xC ACK WO: writing bit0=1 clears pending. Reads return 0.
  - Writes to RO registers are ignored.
- Update event: rising edge of IO_BotUpdt_Sync, detected via a one-flop delayed copy. On the edge cycle, latch IO_BotInfo into the snapshot, set pending, and increment the update count.
- If pending is already 1 at an update edge (and no ACK in the same cycle): missed += 1, saturating at all-ones; the snapshot is still overwritten.
- Simultaneous update edge and ACK write in the same cycle: update wins. Pending stays 1, missed is not incremented, snapshot is updated.
- IO_INT_ACK: asserted for exactly one cycle, the cycle after an ACK write data phase with bit0=1. Back-to-back ACK writes produce back-to-back pulses. An ACK with pending=0 still pulses.
- IO_BotCtrl = BOTCTRL register; it changes the cycle after the write data phase.
- IRQ = pending (registered, no combinational path from inputs).
- Missed counter clears only on reset.
- Reset asserted mid-transfer: the pending data phase is dropped and no write is committed.

Test Plan:
- Reset -> IO_BotCtrl=0, IRQ=0, IO_INT_ACK=0, HREADY=1, HRESP=0; read 0x8 returns 0x00000000.
- Write 0x4=0xFFFFFFA5 -> IO_BotCtrl=0xA5 next cycle; read 0x4 returns 0x000000A5; back-to-back write-then-read returns the new value.
- IO_BotInfo=0x12345678, pulse IO_BotUpdt_Sync for 3 cycles -> one event only; IRQ=1; read 0x0=0x12345678; read 0x8=0x00010001.
- Two update edges without ACK, second with IO_BotInfo=0xCAFEF00D -> read 0x0=0xCAFEF00D; read 0x8=0x00020101.
- Write 0xC=1 -> IO_INT_ACK high exactly one cycle after the data phase; IRQ=0; read 0x8 bit0=0. An update edge in the same cycle as the ACK commit -> IRQ stays 1 and missed is unchanged.
- 300 update edges with no ACK -> missed reads 0xFF (saturated); update count reads 300 (0x012C). Assert HRESETn low mid-write to 0x4 -> IO_BotCtrl=0 immediately; after reset the register is 0.
